// File: rtl/sw_sel_pkg.sv
// Shared types and helpers for the switch-channel selector with auto scan.
package sw_sel_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    FREEZE = 2'd2
  } state_e;

  // Board wiring is reversed: select k drives switch channel n-1-k.
  function automatic int mirror_idx(input int k, input int n);
    return n - 1 - k;
  endfunction

endpackage

// File: rtl/sw_sel_prescaler.sv
// Mod-DIV step prescaler; tick marks the terminal count while enabled.
module sw_sel_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CW'(DIV - 1));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) cnt_d = '0;
    else if (en)     cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sw_sel_scan.sv
// Routes one of N W-bit switch channels to a registered LED output, with manual
// select, automatic scan and hold. Define SW_SEL_SYNC_EN to synchronize all inputs.
module sw_sel_scan #(
  parameter int N        = 8,
  parameter int W        = 1,
  parameter int SEL_W    = $clog2(N),
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] s,
  input  logic             load,
  input  logic             scan_en,
  input  logic             hold,
  input  logic [N*W-1:0]   sw,
  output logic [W-1:0]     led,
  output logic [SEL_W-1:0] sel_q,
  output logic             step
);
  import sw_sel_pkg::*;

  logic [SEL_W-1:0] s_in;
  logic             load_in, scan_in, hold_in;
  logic [N*W-1:0]   sw_in;

`ifdef SW_SEL_SYNC_EN
  logic [SEL_W-1:0] s_m_q, s_s_q;
  logic [N*W-1:0]   sw_m_q, sw_s_q;
  logic [2:0]       load_q;
  logic [1:0]       scan_q, hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_m_q  <= '0;
      s_s_q  <= '0;
      sw_m_q <= '0;
      sw_s_q <= '0;
      load_q <= '0;
      scan_q <= '0;
      hold_q <= '0;
    end else begin
      s_m_q  <= s;
      s_s_q  <= s_m_q;
      sw_m_q <= sw;
      sw_s_q <= sw_m_q;
      load_q <= {load_q[1:0], load};
      scan_q <= {scan_q[0], scan_en};
      hold_q <= {hold_q[0], hold};
    end
  end

  // The third load stage only serves rising-edge detection of the synchronized level.
  assign s_in    = s_s_q;
  assign load_in = load_q[1] & ~load_q[2];
  assign scan_in = scan_q[1];
  assign hold_in = hold_q[1];
  assign sw_in   = sw_s_q;
`else
  assign s_in    = s;
  assign load_in = load;
  assign scan_in = scan_en;
  assign hold_in = hold;
  assign sw_in   = sw;
`endif

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_d, sel_inc;
  logic [W-1:0]     led_q, led_d, chan_sel;
  logic             step_q, step_d;
  logic             load_ok, pre_en, pre_clr, tick;

  assign load_ok  = load_in && (int'(s_in) < N);
  assign sel_inc  = (sel_q == SEL_W'(N - 1)) ? '0 : sel_q + 1'b1;
  assign chan_sel = sw_in[mirror_idx(int'(sel_q), N)*W +: W];

  // Counting happens in SCAN without a load, and on the release cycle of a hold back into scan.
  assign pre_en = !hold_in && scan_in &&
                  ((state_q == SCAN && !load_in) || state_q == FREEZE);

  sw_sel_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    led_d   = chan_sel;
    step_d  = 1'b0;
    pre_clr = 1'b0;
    if (hold_in) begin
      state_d = FREEZE;
      led_d   = led_q;
    end else begin
      unique case (state_q)
        MANUAL: begin
          if (load_ok) sel_d = s_in;
          if (scan_in) begin
            state_d = SCAN;
            pre_clr = 1'b1;
          end
        end
        SCAN: begin
          if (load_in) begin
            if (load_ok) sel_d = s_in;
            pre_clr = 1'b1;
          end else if (tick) begin
            sel_d  = sel_inc;
            step_d = 1'b1;
          end
          if (!scan_in) begin
            state_d = MANUAL;
            pre_clr = 1'b1;
          end
        end
        FREEZE: begin
          state_d = scan_in ? SCAN : MANUAL;
          if (tick) begin
            sel_d  = sel_inc;
            step_d = 1'b1;
          end
        end
        default: state_d = MANUAL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MANUAL;
      sel_q   <= '0;
      led_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      led_q   <= led_d;
      step_q  <= step_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_sw_sel_scan.sv
// Directed scoreboard bench for sw_sel_scan: N=8/W=1, N=6 and W=4 instances, SCAN_DIV=4.
module tb_sw_sel_scan;

  logic clk;

  logic       a_rst, a_load, a_scan, a_hold, a_step;
  logic [2:0] a_s, a_sel;
  logic [7:0] a_sw;
  logic [0:0] a_led;

  logic       b_rst, b_load, b_scan, b_hold, b_step;
  logic [2:0] b_s, b_sel;
  logic [5:0] b_sw;
  logic [0:0] b_led;

  logic        c_rst, c_load, c_scan, c_hold, c_step;
  logic [2:0]  c_s, c_sel;
  logic [31:0] c_sw;
  logic [3:0]  c_led;

  sw_sel_scan #(.N(8), .W(1), .SCAN_DIV(4)) dut_a (
    .clk(clk), .rst(a_rst), .s(a_s), .load(a_load), .scan_en(a_scan), .hold(a_hold),
    .sw(a_sw), .led(a_led), .sel_q(a_sel), .step(a_step));

  sw_sel_scan #(.N(6), .W(1), .SCAN_DIV(4)) dut_b (
    .clk(clk), .rst(b_rst), .s(b_s), .load(b_load), .scan_en(b_scan), .hold(b_hold),
    .sw(b_sw), .led(b_led), .sel_q(b_sel), .step(b_step));

  sw_sel_scan #(.N(8), .W(4), .SCAN_DIV(4)) dut_c (
    .clk(clk), .rst(c_rst), .s(c_s), .load(c_load), .scan_en(c_scan), .hold(c_hold),
    .sw(c_sw), .led(c_led), .sel_q(c_sel), .step(c_step));

  typedef struct {
    string       tag;
    int          unit;
    logic [31:0] led;
    logic [31:0] sel;
    logic [31:0] step;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input int unit, input logic [31:0] l,
                      input logic [31:0] sl, input logic [31:0] st);
    exp_t e;
    e.tag = tag; e.unit = unit; e.led = l; e.sel = sl; e.step = st;
    sb.push_back(e);
  endtask

  // Advance one clock, compare every queued expectation, return at the falling edge.
  task automatic cyc();
    exp_t e;
    logic [31:0] al, asl, ast;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.unit)
        0:       begin al = 32'(a_led); asl = 32'(a_sel); ast = 32'(a_step); end
        1:       begin al = 32'(b_led); asl = 32'(b_sel); ast = 32'(b_step); end
        default: begin al = 32'(c_led); asl = 32'(c_sel); ast = 32'(c_step); end
      endcase
      chk({e.tag, "_led"}, al, e.led);
      chk({e.tag, "_sel"}, asl, e.sel);
      chk({e.tag, "_step"}, ast, e.step);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] ch_a(input int sel);
    return 32'(a_sw[7 - sel]);
  endfunction

  function automatic logic [31:0] ch_b(input int sel);
    return 32'(b_sw[5 - sel]);
  endfunction

  initial begin
    logic [31:0] old_led;
    a_rst = 1'b1; a_s = '0; a_load = 1'b0; a_scan = 1'b0; a_hold = 1'b0; a_sw = 8'b0000_0001;
    b_rst = 1'b1; b_s = '0; b_load = 1'b0; b_scan = 1'b0; b_hold = 1'b0; b_sw = 6'b10_1100;
    c_rst = 1'b1; c_s = '0; c_load = 1'b0; c_scan = 1'b0; c_hold = 1'b0; c_sw = 32'h7654_3210;
    @(posedge clk);
    #1;
    chk("rst_led", 32'(a_led), 0);
    chk("rst_sel", 32'(a_sel), 0);
    chk("rst_step", 32'(a_step), 0);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

`ifdef SW_SEL_SYNC_EN
    a_sw = 8'h80;
    push("sync_sw_e1", 0, 0, 0, 0); cyc();
    push("sync_sw_e2", 0, 0, 0, 0); cyc();
    push("sync_sw_e3", 0, 1, 0, 0); cyc();
    a_s = 3'd5; a_load = 1'b1;
    push("sync_ld_c1", 0, 1, 0, 0); cyc();
    a_s = 3'd2;
    push("sync_ld_c2", 0, 1, 0, 0); cyc();
    push("sync_ld_c3", 0, 1, 5, 0); cyc();
    a_load = 1'b0;
    push("sync_ld_c4", 0, 0, 5, 0); cyc();
    push("sync_ld_c5", 0, 0, 5, 0); cyc();
    push("sync_ld_c6", 0, 0, 5, 0); cyc();
`else
    // Manual select with the reversed board mapping.
    push("idle", 0, 0, 0, 0); cyc();
    a_s = 3'd7; a_load = 1'b1;
    push("load7", 0, 0, 7, 0); cyc();
    a_load = 1'b0;
    push("load7_led", 0, 1, 7, 0); cyc();

    // Full scan lap from select 0.
    a_sw = 8'b1011_0010; a_s = 3'd0; a_load = 1'b1;
    push("load0", 0, ch_a(7), 0, 0); cyc();
    a_load = 1'b0; a_scan = 1'b1;
    push("scan_entry", 0, ch_a(0), 0, 0); cyc();
    for (int j = 1; j <= 8; j++) begin
      for (int i = 1; i <= 4; i++) begin
        push($sformatf("scan_j%0d_i%0d", j, i), 0, ch_a((j - 1) % 8),
             (i == 4) ? 32'(j % 8) : 32'(j - 1), (i == 4) ? 1 : 0);
        cyc();
      end
    end

    // Hold two counts into the next step period, then release.
    push("prehold1", 0, ch_a(0), 0, 0); cyc();
    push("prehold2", 0, ch_a(0), 0, 0); cyc();
    a_hold = 1'b1;
    old_led = ch_a(0);
    a_sw = ~a_sw;
    for (int i = 0; i < 10; i++) begin
      push($sformatf("hold%0d", i), 0, old_led, 0, 0);
      cyc();
    end
    a_hold = 1'b0;
    push("release", 0, ch_a(0), 0, 0); cyc();
    push("resume_step", 0, ch_a(0), 1, 1); cyc();

    a_scan = 1'b0;
    push("exit_scan", 0, ch_a(1), 1, 0); cyc();
    for (int i = 0; i < 4; i++) begin
      push($sformatf("manual%0d", i), 0, ch_a(1), 1, 0);
      cyc();
    end

    // N=6: out-of-range loads ignored; load wins over a coinciding terminal count.
    b_s = 3'd3; b_load = 1'b1;
    push("n6_load3", 1, ch_b(0), 3, 0); cyc();
    b_s = 3'd6;
    push("n6_load6", 1, ch_b(3), 3, 0); cyc();
    b_s = 3'd7;
    push("n6_load7", 1, ch_b(3), 3, 0); cyc();
    b_load = 1'b0; b_scan = 1'b1;
    push("n6_scan_entry", 1, ch_b(3), 3, 0); cyc();
    for (int i = 1; i <= 3; i++) begin
      push($sformatf("n6_cnt%0d", i), 1, ch_b(3), 3, 0);
      cyc();
    end
    b_s = 3'd1; b_load = 1'b1;
    push("n6_load_at_tc", 1, ch_b(3), 1, 0); cyc();
    b_load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      push($sformatf("n6_restart%0d", i), 1, ch_b(1), 1, 0);
      cyc();
    end
    push("n6_step", 1, ch_b(1), 2, 1); cyc();
    b_scan = 1'b0;

    // W=4: asynchronous reset in the middle of a scan.
    c_s = 3'd2; c_load = 1'b1;
    push("w4_load2", 2, 7, 2, 0); cyc();
    c_load = 1'b0; c_scan = 1'b1;
    push("w4_scan_entry", 2, 5, 2, 0); cyc();
    for (int i = 1; i <= 3; i++) begin
      push($sformatf("w4_cnt%0d", i), 2, 5, 2, 0);
      cyc();
    end
    push("w4_step", 2, 5, 3, 1); cyc();
    push("w4_led3", 2, 4, 3, 0); cyc();
    #2;
    c_rst = 1'b1;
    #1;
    chk("w4_async_rst_led", 32'(c_led), 0);
    chk("w4_async_rst_sel", 32'(c_sel), 0);
    chk("w4_async_rst_step", 32'(c_step), 0);
    @(negedge clk);
    c_rst = 1'b0;
    push("w4_post_rst", 2, 7, 0, 0); cyc();
    for (int i = 1; i <= 3; i++) begin
      push($sformatf("w4_post_cnt%0d", i), 2, 7, 0, 0);
      cyc();
    end
    push("w4_post_step", 2, 7, 1, 1); cyc();
    c_scan = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
